// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer: full-throughput
// valid/ready handshake where in_ready comes straight from a flop, plus
// flush, synchronous reset and a saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int unsigned     DW      = 134,
  parameter logic [DW-1:0]   NOP_VAL = {32'h0000_0013, {(DW-32){1'b0}}},
  parameter int unsigned     CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [DW-1:0]    r_main;
  logic [DW-1:0]    r_skid;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_stall_cnt;

  state_t           w_state_nxt;
  logic [DW-1:0]    w_main_nxt;
  logic [DW-1:0]    w_skid_nxt;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;
  logic [CNT_W-1:0] w_stall_cnt_nxt;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Next-state, storage and registered-handshake computation.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_nxt      = r_main;
    w_skid_nxt      = r_skid;
    w_stall_cnt_nxt = r_stall_cnt;

    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = ONE;
          w_main_nxt  = in_data;
        end
      end
      ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_nxt = in_data;
        end else if (w_in_fire) begin
          w_state_nxt = FULL;
          w_skid_nxt  = in_data;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY;
          w_main_nxt  = NOP_VAL;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_state_nxt = ONE;
          w_main_nxt  = r_skid;
          w_skid_nxt  = NOP_VAL;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
        w_main_nxt  = NOP_VAL;
        w_skid_nxt  = NOP_VAL;
      end
    endcase

    // Kill overrides every transition; a delivery this cycle still happened.
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = NOP_VAL;
      w_skid_nxt  = NOP_VAL;
    end

    w_in_ready_nxt  = (w_state_nxt != FULL);
    w_out_valid_nxt = (w_state_nxt != EMPTY);

    if (r_out_valid && !out_ready && (r_stall_cnt != STALL_MAX)) begin
      w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
    end
  end

  // State and storage registers; reset beats flush and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_main      <= NOP_VAL;
      r_skid      <= NOP_VAL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a randomized run
// against a queue-based reference model of the stage.
module tb_pipe_stage_reg;

  localparam int unsigned DW    = 134;
  localparam int unsigned CNT_W = 4;
  localparam int          SMAX  = 15;
  localparam logic [DW-1:0] NOP = {32'h0000_0013, 102'd0};

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks;
  int n_fail;

  // Reference model: held payloads in arrival order, and the stall count.
  logic [DW-1:0] q[$];
  int            m_stall;

  pipe_stage_reg #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_payload();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return DW'(r);
  endfunction

  function automatic logic [DW-1:0] exp_data();
    logic [DW-1:0] h;
    h = NOP;
    if (q.size() > 0) h = q[0];
    return h;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic orr,
                       input logic fl, input logic r);
    bit ifire;
    bit ofire;
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    flush     = fl;
    rst       = r;
    ifire = iv && (q.size() < 2);
    ofire = (q.size() > 0) && orr;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_stall = 0;
    end else begin
      if ((q.size() > 0) && !orr && (m_stall < SMAX)) m_stall++;
      if (fl) begin
        q.delete();
      end else begin
        if (ofire) void'(q.pop_front());
        if (ifire) q.push_back(d);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, rand_payload(), 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== NOP || stall_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h stall=%0d, want 1 0 %h 0",
               in_ready, out_valid, out_data, stall_cnt, NOP);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] pl[4];
    for (int i = 0; i < 4; i++) pl[i] = rand_payload();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pl[i], 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== pl[i] || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%b data=%h ready=%b, want 1 %h 1",
                 i, out_valid, out_data, in_ready, pl[i]);
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== NOP) begin
      n_fail++;
      $display("FAIL stream_drain: valid=%b data=%h, want 0 %h", out_valid, out_data, NOP);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    a = rand_payload();
    b = rand_payload();
    drive(1'b1, a, 1'b0, 1'b0, 1'b0);
    drive(1'b1, b, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b0 || out_data !== a || stall_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL bp_full: ready=%b data=%h stall=%0d, want 0 %h 1",
               in_ready, out_data, stall_cnt, a);
    end
    drive(1'b1, rand_payload(), 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b0 || stall_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL bp_hold: ready=%b stall=%0d, want 0 3", in_ready, stall_cnt);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== b || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: valid=%b data=%h ready=%b, want 1 %h 1",
               out_valid, out_data, in_ready, b);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== NOP || stall_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL bp_drain: valid=%b data=%h stall=%0d, want 0 %h 3",
               out_valid, out_data, stall_cnt, NOP);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, rand_payload(), 1'b0, 1'b0, 1'b0);
    drive(1'b1, rand_payload(), 1'b0, 1'b0, 1'b0);
    drive(1'b1, rand_payload(), 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== NOP || in_ready !== 1'b1 || 32'(stall_cnt) !== m_stall) begin
      n_fail++;
      $display("FAIL flush: valid=%b data=%h ready=%b stall=%0d, want 0 %h 1 %0d",
               out_valid, out_data, in_ready, stall_cnt, NOP, m_stall);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== NOP) begin
        n_fail++;
        $display("FAIL flush_ghost[%0d]: valid=%b data=%h, want 0 %h", i, out_valid, out_data, NOP);
      end
    end
  endtask

  task automatic test_saturation();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, rand_payload(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (32'(stall_cnt) !== ((i + 1 > SMAX) ? SMAX : i + 1)) begin
        n_fail++;
        $display("FAIL saturate[%0d]: stall=%0d, want %0d", i, stall_cnt,
                 (i + 1 > SMAX) ? SMAX : i + 1);
      end
    end
  endtask

  task automatic test_reset_full();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, rand_payload(), 1'b0, 1'b0, 1'b0);
    drive(1'b1, rand_payload(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (stall_cnt !== 4'd7 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_full_pre: stall=%0d ready=%b, want 7 0", stall_cnt, in_ready);
    end
    drive(1'b1, rand_payload(), 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== NOP || stall_cnt !== 4'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_full: valid=%b data=%h stall=%0d ready=%b, want 0 %h 0 1",
               out_valid, out_data, stall_cnt, in_ready, NOP);
    end
  endtask

  task automatic test_random();
    bit iv;
    bit orr;
    bit fl;
    bit r;
    bit exp_ready;
    for (int i = 0; i < 10000; i++) begin
      iv  = ($urandom_range(0, 9) < 7);
      orr = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 15) == 0);
      r   = ($urandom_range(0, 499) == 0);
      drive(iv, rand_payload(), orr, fl, r);
      exp_ready = (q.size() < 2);
      n_checks++;
      if (in_ready !== exp_ready || out_valid !== (q.size() > 0) ||
          out_data !== exp_data() || 32'(stall_cnt) !== m_stall) begin
        n_fail++;
        $display("FAIL random[%0d]: ready=%b valid=%b data=%h stall=%0d, want %b %b %h %0d",
                 i, in_ready, out_valid, out_data, stall_cnt,
                 exp_ready, (q.size() > 0), exp_data(), m_stall);
      end
      out_ready = ~out_ready;
      #1;
      n_checks++;
      if (in_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL ready_comb[%0d]: ready=%b after out_ready toggle, want %b",
                 i, in_ready, exp_ready);
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_stall   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturation();
    test_reset_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
